// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multicycle MIPS control FSM with memory handshake, retire counter,
//            illegal-opcode and memory-timeout flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int CNT_W           = 32,
  parameter int MAX_WAIT        = 16,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             illegal_o,
  output logic             bus_error_o
);

  localparam int          c_WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [5:0]  c_OP_RTYPE = 6'b000000;
  localparam logic [5:0]  c_OP_ADDI  = 6'b001000;
  localparam logic [5:0]  c_OP_ANDI  = 6'b001100;
  localparam logic [5:0]  c_OP_LW    = 6'b100011;
  localparam logic [5:0]  c_OP_SW    = 6'b101011;
  localparam logic [5:0]  c_OP_BEQ   = 6'b000100;
  localparam logic [5:0]  c_OP_BNE   = 6'b000101;
  localparam logic [5:0]  c_OP_J     = 6'b000010;
  localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [c_WAIT_W-1:0] wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                bus_error_q, bus_error_d;
  logic                w_wait_state;
  logic                w_timeout;

  assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // A ready seen on the same cycle as the limit still completes normally.
  assign w_timeout    = (MAX_WAIT != 0) && w_wait_state && !mem_ready_i && (wait_q == c_MAX_WAIT);

  always_comb begin
    state_d      = state_q;
    retired_d    = retired_q;
    illegal_d    = illegal_q;
    bus_error_d  = bus_error_q;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    pc_source_o  = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (w_timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          c_OP_RTYPE:           state_d = S_EXEC_R;
          c_OP_ADDI, c_OP_ANDI: state_d = S_EXEC_I;
          c_OP_LW, c_OP_SW:     state_d = S_MEM_ADDR;
          c_OP_BEQ, c_OP_BNE:   state_d = S_BRANCH;
          c_OP_J:               state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_d     = S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (opcode_i == c_OP_ANDI) ? 2'b11 : 2'b00;
        state_d     = S_WB_I;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEM_WB;
        end else if (w_timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retired_d    = retired_q + 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          retired_d = retired_q + 1'b1;
          state_d   = S_FETCH;
        end else if (w_timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retired_d   = retired_q + 1'b1;
        state_d     = S_FETCH;
      end
      S_WB_I: begin
        reg_write_o = 1'b1;
        retired_d   = retired_q + 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_source_o = 2'b01;
        pc_write_o  = ((opcode_i == c_OP_BEQ) && zero_i) || ((opcode_i == c_OP_BNE) && !zero_i);
        retired_d   = retired_q + 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
        retired_d   = retired_q + 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((MAX_WAIT != 0) && w_wait_state && !mem_ready_i) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end

    // Strobes must not fire from the reset-state decode while rst is held.
    if (rst) begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      i_or_d_o     = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      pc_source_o  = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      retired_q   <= '0;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign state_o     = state_q;
  assign retired_o   = retired_q;
  assign illegal_o   = illegal_q;
  assign bus_error_o = bus_error_q;

endmodule

`default_nettype wire
